// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: PC-stage handshake, byte-wide memory port and decode-side result.
interface inst_fetch_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_reg_stall;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [7:0]  mem_data_i;
  logic        id_stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  // Fetch unit side
  modport master (
    input  pc_i, pc_valid_i, mem_rdy_i, mem_data_i, id_stall_i,
    output pc_reg_stall, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

  // Environment side (PC stage, memory controller, decode)
  modport slave (
    output pc_i, pc_valid_i, mem_rdy_i, mem_data_i, id_stall_i,
    input  pc_reg_stall, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with a direct-mapped one-word-per-line icache, refilled a byte at a time.
module inst_fetch #(
  parameter int unsigned IDX_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          jump_or_not,
  inst_fetch_if.master  bus
);

  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t           state, state_n;
  logic [1:0]       cnt, cnt_n;
  logic [31:0]      pc_lat, pc_lat_n;
  logic [2:0][7:0]  byte_buf, byte_buf_n;
  logic             inst_valid_n;
  logic [31:0]      inst_n, inst_pc_n;
  logic             mem_req_n;
  logic [31:0]      mem_addr_n;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             hit;
  logic             fill_we;
  logic [31:0]      fill_word;

  assign pc_idx    = bus.pc_i[IDX_W+1:2];
  assign pc_tag    = bus.pc_i[31:IDX_W+2];
  assign fill_idx  = pc_lat[IDX_W+1:2];
  assign fill_tag  = pc_lat[31:IDX_W+2];
  assign hit       = line_valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign fill_word = {bus.mem_data_i, byte_buf[2], byte_buf[1], byte_buf[0]};

  // Hold the PC stage while refilling, holding a result, on a pending miss, or when decode is full
  assign bus.pc_reg_stall = (state != IDLE) ||
                            (bus.pc_valid_i && !hit) ||
                            bus.id_stall_i;

  // Next-state and next-output logic; flush beats freeze, freeze keeps everything
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_lat_n     = pc_lat;
    byte_buf_n   = byte_buf;
    inst_valid_n = bus.inst_valid_o;
    inst_n       = bus.inst_o;
    inst_pc_n    = bus.inst_pc_o;
    fill_we      = 1'b0;

    if (jump_or_not) begin
      state_n      = IDLE;
      cnt_n        = 2'd0;
      inst_valid_n = 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          inst_valid_n = 1'b0;
          if (bus.pc_valid_i) begin
            if (hit) begin
              inst_n       = data_mem[pc_idx];
              inst_pc_n    = bus.pc_i;
              inst_valid_n = 1'b1;
              state_n      = bus.id_stall_i ? HOLD : IDLE;
            end else begin
              pc_lat_n = bus.pc_i;
              cnt_n    = 2'd0;
              state_n  = FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.mem_rdy_i) begin
            if (cnt == 2'd3) begin
              fill_we      = 1'b1;
              inst_n       = fill_word;
              inst_pc_n    = pc_lat;
              inst_valid_n = 1'b1;
              cnt_n        = 2'd0;
              state_n      = bus.id_stall_i ? HOLD : IDLE;
            end else begin
              byte_buf_n[cnt] = bus.mem_data_i;
              cnt_n           = cnt + 2'd1;
            end
          end
        end
        HOLD: begin
          if (!bus.id_stall_i) begin
            inst_valid_n = 1'b0;
            state_n      = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    mem_req_n  = (state_n == FETCH);
    mem_addr_n = mem_req_n ? (pc_lat_n + 32'(cnt_n)) : 32'd0;
  end

  // State, control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 2'd0;
      pc_lat           <= 32'd0;
      byte_buf         <= '0;
      line_valid       <= '0;
      bus.inst_valid_o <= 1'b0;
      bus.inst_o       <= 32'd0;
      bus.inst_pc_o    <= 32'd0;
      bus.mem_req_o    <= 1'b0;
      bus.mem_addr_o   <= 32'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      pc_lat           <= pc_lat_n;
      byte_buf         <= byte_buf_n;
      bus.inst_valid_o <= inst_valid_n;
      bus.inst_o       <= inst_n;
      bus.inst_pc_o    <= inst_pc_n;
      bus.mem_req_o    <= mem_req_n;
      bus.mem_addr_o   <= mem_addr_n;
      if (fill_we) line_valid[fill_idx] <= 1'b1;
    end
  end

  // Cache tag/data arrays; no reset needed since line_valid gates their use
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_word;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed stimulus with a result scoreboard.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic jump;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.IDX_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .jump_or_not (jump),
    .bus         (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop one expectation each time decode accepts a valid result
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.inst_valid_o === 1'b1 && bus.id_stall_i === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_inst", bus.inst_o, e.inst);
        check("sb_pc", bus.inst_pc_o, e.pc);
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.inst = word;
    sb_q.push_back(e);
  endtask

  task automatic start_miss(input logic [31:0] pc);
    bus.pc_i       = pc;
    bus.pc_valid_i = 1'b1;
    #1;
    check("miss_stall", 32'(bus.pc_reg_stall), 32'd1);
    step();
    bus.pc_valid_i = 1'b0;
    bus.pc_i       = 32'd0;
  endtask

  task automatic serve(input logic [31:0] pc, input logic [31:0] word, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      check("mem_req", 32'(bus.mem_req_o), 32'd1);
      check("mem_addr", bus.mem_addr_o, pc + 32'(k));
      check("fetch_stall", 32'(bus.pc_reg_stall), 32'd1);
      bus.mem_rdy_i  = 1'b1;
      bus.mem_data_i = word[8*k +: 8];
      step();
      bus.mem_rdy_i  = 1'b0;
      bus.mem_data_i = 8'd0;
    end
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] word);
    start_miss(pc);
    push_exp(pc, word);
    serve(pc, word, 0, 3);
    check("done_valid", 32'(bus.inst_valid_o), 32'd1);
    check("done_req", 32'(bus.mem_req_o), 32'd0);
    check("done_addr", bus.mem_addr_o, 32'd0);
    step();
    check("pulse_end", 32'(bus.inst_valid_o), 32'd0);
  endtask

  task automatic hit(input logic [31:0] pc, input logic [31:0] word);
    bus.pc_i       = pc;
    bus.pc_valid_i = 1'b1;
    #1;
    check("hit_stall", 32'(bus.pc_reg_stall), 32'd0);
    push_exp(pc, word);
    step();
    bus.pc_valid_i = 1'b0;
    bus.pc_i       = 32'd0;
    check("hit_req", 32'(bus.mem_req_o), 32'd0);
    check("hit_valid", 32'(bus.inst_valid_o), 32'd1);
    step();
    check("hit_pulse_end", 32'(bus.inst_valid_o), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    jump           = 1'b0;
    bus.pc_i       = 32'd0;
    bus.pc_valid_i = 1'b0;
    bus.mem_rdy_i  = 1'b0;
    bus.mem_data_i = 8'd0;
    bus.id_stall_i = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst_inst", bus.inst_o, 32'd0);
    check("rst_pc", bus.inst_pc_o, 32'd0);
    check("rst_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'd0);
    check("rst_stall", 32'(bus.pc_reg_stall), 32'd0);
    rst = 1'b0;
    step();

    // Cold miss then hit
    fetch_miss(32'h0, 32'h0010_0513);
    hit(32'h0, 32'h0010_0513);

    // Conflict on index 0: 0x80 evicts 0x0, which then misses again
    fetch_miss(32'h80, 32'hDEAD_BEEF);
    fetch_miss(32'h0, 32'h0010_0513);
    hit(32'h0, 32'h0010_0513);

    // Flush after two bytes: no result, no cache write
    start_miss(32'h100);
    serve(32'h100, 32'h1234_5678, 0, 1);
    jump = 1'b1;
    step();
    jump = 1'b0;
    check("flush_req", 32'(bus.mem_req_o), 32'd0);
    check("flush_addr", bus.mem_addr_o, 32'd0);
    check("flush_valid", 32'(bus.inst_valid_o), 32'd0);
    step();
    step();
    fetch_miss(32'h100, 32'h1234_5678);

    // Backpressure at completion: result held until decode frees up
    start_miss(32'h200);
    push_exp(32'h200, 32'hCAFE_F00D);
    serve(32'h200, 32'hCAFE_F00D, 0, 2);
    bus.id_stall_i = 1'b1;
    serve(32'h200, 32'hCAFE_F00D, 3, 3);
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
      check("hold_inst", bus.inst_o, 32'hCAFE_F00D);
      check("hold_pc", bus.inst_pc_o, 32'h200);
      check("hold_req", 32'(bus.mem_req_o), 32'd0);
      check("hold_stall", 32'(bus.pc_reg_stall), 32'd1);
      if (c < 2) step();
    end
    bus.id_stall_i = 1'b0;
    step();
    check("hold_release", 32'(bus.inst_valid_o), 32'd0);

    // Freeze for two cycles mid-refill
    start_miss(32'h300);
    push_exp(32'h300, 32'hA1B2_C3D4);
    serve(32'h300, 32'hA1B2_C3D4, 0, 1);
    rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("frz_req", 32'(bus.mem_req_o), 32'd1);
      check("frz_addr", bus.mem_addr_o, 32'h302);
      check("frz_valid", 32'(bus.inst_valid_o), 32'd0);
    end
    rdy = 1'b1;
    serve(32'h300, 32'hA1B2_C3D4, 2, 3);
    check("frz_done_valid", 32'(bus.inst_valid_o), 32'd1);
    step();
    check("frz_pulse_end", 32'(bus.inst_valid_o), 32'd0);

    // Stray memory response while idle has no effect
    bus.mem_rdy_i  = 1'b1;
    bus.mem_data_i = 8'hFF;
    step();
    bus.mem_rdy_i  = 1'b0;
    bus.mem_data_i = 8'd0;
    check("stray_req", 32'(bus.mem_req_o), 32'd0);
    check("stray_valid", 32'(bus.inst_valid_o), 32'd0);
    hit(32'h300, 32'hA1B2_C3D4);

    // Reset mid-refill with rdy low: aborts and invalidates the cache
    start_miss(32'h400);
    serve(32'h400, 32'h5555_AAAA, 0, 1);
    rst = 1'b1;
    rdy = 1'b0;
    step();
    rst = 1'b0;
    rdy = 1'b1;
    check("rst2_req", 32'(bus.mem_req_o), 32'd0);
    check("rst2_addr", bus.mem_addr_o, 32'd0);
    check("rst2_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst2_inst", bus.inst_o, 32'd0);
    fetch_miss(32'h0, 32'h0010_0513);

    step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
